// File: rtl/e_rr_arb_if.sv
// Request/grant bundle between the requesting agents (master) and the round-robin arbiter (slave).
// The arbiter drives the grant and status fields; requesters drive the request levels and completion.
interface e_rr_arb_if #(
  parameter int N = 4
) ();
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     i_req;
  logic             i_done;
  logic [N-1:0]     o_gnt;
  logic [IDX_W-1:0] o_gnt_idx;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_req, i_done,
    input  o_gnt, o_gnt_idx, o_busy, o_err
  );

  modport slave (
    input  i_req, i_done,
    output o_gnt, o_gnt_idx, o_busy, o_err
  );
endinterface

// File: rtl/e_rr_arb.sv
// Round-robin arbiter with registered one-hot grant: request to grant in 1 cycle, grant held until i_done.
// E_RR_ARB_ONEHOT_CHK_EN adds a sticky grant-invariant checker on o_err; otherwise o_err is tied low.
module e_rr_arb #(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  e_rr_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ptr_ho;
  logic             idle_found, ho_found;
  logic [IDX_W-1:0] idle_win, ho_win;

  // First set bit of req scanning start, start+1, ... wrapping modulo N.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0]     req,
                                             input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] pos;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(start) + k) % N);
      if (!found && req[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign ptr_ho = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

  // The handover search masks the current owner so it never wins back-to-back.
  always_comb begin
    {idle_found, idle_win} = rr_pick(bus.i_req, ptr_q);
    {ho_found, ho_win}     = rr_pick(bus.i_req & ~gnt_q, ptr_ho);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (idle_found) state_d = BUSY;
      BUSY:    if (bus.i_done && !ho_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          gnt_d = onehot(idle_win);
          idx_d = idle_win;
        end
      end
      BUSY: begin
        if (bus.i_done) begin
          ptr_d = ptr_ho;
          if (ho_found) begin
            gnt_d = onehot(ho_win);
            idx_d = ho_win;
          end else begin
            gnt_d = '0;
            idx_d = '0;
          end
        end
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_gnt_idx = idx_q;
  assign bus.o_busy    = |gnt_q;

`ifdef E_RR_ARB_ONEHOT_CHK_EN
  logic err_q, err_d;
  logic gnt_ok;

  // Watches the grant as seen on the bus, so it also catches a corrupted output net.
  always_comb begin
    gnt_ok = (bus.o_gnt == '0) ? (bus.o_gnt_idx == '0)
                               : (bus.o_gnt == onehot(bus.o_gnt_idx));
    err_d  = err_q | ~gnt_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
endmodule
